// File: rtl/ram_loader.sv
// Purpose : loads a program RAM from a framed byte stream (A5, N, N x {hi,lo}, checksum) while stalling the CPU.
// Latency : mem_we fires one cycle after the lo-byte handshake; done/error pulse one cycle after the checksum byte.
// Backpressure: rx_ready drops only during the single WRITE cycle of each word; a byte is taken when rx_valid && rx_ready.
//
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-high reset
//   rx_data/rx_valid    - byte stream from the serial receiver
//   rx_ready            - loader accepts a byte this cycle
//   mem_addr/mem_din    - RAM address / write data, held between writes
//   mem_we              - one-cycle RAM write strobe
//   cpu_hold            - high while a frame is being loaded
//   done / error        - one-cycle completion pulses (good checksum / abort)
module ram_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 12,
    parameter int TIMEOUT    = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_we,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_HI, S_LO, S_WRITE, S_CHECK
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_din;
    logic [DATA_WIDTH-9:0] r_hi;
    logic [7:0]            r_csum;
    logic [TW-1:0]         r_tmo;
    logic                  r_done;
    logic                  r_err;

    logic                  w_acc;
    logic                  w_tmo;
    logic                  w_last;
    logic                  w_done_nxt;
    logic                  w_err_nxt;
    logic [DATA_WIDTH-1:0] w_word;

    assign rx_ready = (r_state != S_WRITE);
    assign mem_we   = (r_state == S_WRITE);
    assign cpu_hold = (r_state != S_IDLE);
    assign mem_addr = r_addr;
    assign mem_din  = r_din;
    assign done     = r_done;
    assign error    = r_err;

    assign w_acc  = rx_valid && rx_ready;
    assign w_word = {r_hi, rx_data};
    // A latched count of 0 makes cnt-1 all ones, so every address is written once.
    assign w_last = (r_idx == (r_cnt - ADDR_WIDTH'(1)));
    // An accepted byte on the final cycle wins over the timeout.
    assign w_tmo  = (r_state != S_IDLE) && (r_state != S_WRITE)
                    && !w_acc && (r_tmo == TMO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_done_nxt = 1'b0;
        w_err_nxt  = 1'b0;
        case (r_state)
            S_IDLE:  if (w_acc && rx_data == 8'hA5) w_next = S_COUNT;
            S_COUNT: if (w_acc) w_next = S_HI;
            S_HI:    if (w_acc) w_next = S_LO;
            S_LO:    if (w_acc) w_next = S_WRITE;
            S_WRITE: w_next = w_last ? S_CHECK : S_HI;
            S_CHECK: begin
                if (w_acc) begin
                    w_next = S_IDLE;
                    if (rx_data == r_csum) w_done_nxt = 1'b1;
                    else                   w_err_nxt  = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (w_tmo) begin
            w_next    = S_IDLE;
            w_err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            r_addr <= '0;
            r_din  <= '0;
            r_hi   <= '0;
            r_csum <= '0;
            r_tmo  <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;

            // Counter freezes across WRITE; that cycle is the loader's own stall.
            if (r_state == S_IDLE || w_acc || w_tmo) begin
                r_tmo <= '0;
            end else if (r_state != S_WRITE) begin
                r_tmo <= r_tmo + TW'(1);
            end

            if (w_acc) begin
                case (r_state)
                    S_COUNT: begin
                        r_cnt  <= ADDR_WIDTH'(rx_data);
                        r_idx  <= '0;
                        r_csum <= '0;
                    end
                    S_HI: begin
                        r_hi   <= rx_data[DATA_WIDTH-9:0];
                        r_csum <= r_csum + rx_data;
                    end
                    S_LO: begin
                        r_csum <= r_csum + rx_data;
                        r_addr <= r_idx;
                        r_din  <= w_word;
                    end
                    default: ;
                endcase
            end

            if (r_state == S_WRITE) begin
                r_idx <= r_idx + ADDR_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
module tb_ram_loader;
    localparam int AW  = 4;
    localparam int DW  = 12;
    localparam int TMO = 40;
    localparam int NW  = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_we;
    logic          cpu_hold;
    logic          done;
    logic          error;

    ram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_we(mem_we), .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Monitor-owned observations (cumulative; the stimulus side only reads them).
    logic [31:0] obs_addr_q[$];
    logic [31:0] obs_data_q[$];
    int done_cnt = 0, err_cnt = 0, hold_viol = 0, ready_viol = 0, acc_cnt = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                obs_addr_q.push_back(32'(mem_addr));
                obs_data_q.push_back(32'(mem_din));
            end
            if (done)  done_cnt++;
            if (error) err_cnt++;
            if ((done || error) && cpu_hold) hold_viol++;
            if (rx_ready !== !mem_we) ready_viol++;
            if (rx_valid && rx_ready) acc_cnt++;
        end
    end

    // Reference model state: frame bytes and the writes/outcome they imply.
    logic [7:0]  frame_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [7:0]  hi_a[NW];
    logic [7:0]  lo_a[NW];
    bit          exp_ok;
    int b_obs, b_done, b_err, b_hold, b_ready, b_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            hi_a[i] = 8'($urandom);
            lo_a[i] = 8'($urandom);
        end
    endtask

    // n words; ck_override >= 0 forces the checksum byte, corrupt perturbs it.
    task automatic build_frame(input int n, input int ck_override, input bit corrupt);
        int sum = 0;
        int ck;
        frame_q.delete();
        exp_addr_q.delete();
        exp_data_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'((n == NW) ? 0 : n));
        for (int i = 0; i < n; i++) begin
            frame_q.push_back(hi_a[i]);
            frame_q.push_back(lo_a[i]);
            sum = (sum + int'(hi_a[i]) + int'(lo_a[i])) % 256;
            exp_addr_q.push_back(32'(i % NW));
            exp_data_q.push_back(32'((int'(hi_a[i]) * 256 + int'(lo_a[i])) % (1 << DW)));
        end
        if (ck_override >= 0) ck = ck_override;
        else if (corrupt)     ck = (sum + 1 + int'($urandom_range(253, 0))) % 256;
        else                  ck = sum;
        frame_q.push_back(8'(ck));
        exp_ok = (ck == sum);
    endtask

    task automatic mark();
        b_obs   = obs_addr_q.size();
        b_done  = done_cnt;
        b_err   = err_cnt;
        b_hold  = hold_viol;
        b_ready = ready_viol;
        b_acc   = acc_cnt;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int guard = 0;
        repeat (gap) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) chk("send_stall", 32'(guard), 32'd0);
        @(posedge clk);
    endtask

    task automatic go_idle();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int maxgap, input int last_gap);
        for (int i = 0; i < frame_q.size(); i++) begin
            if (i == frame_q.size() - 1 && last_gap >= 0) send(frame_q[i], last_gap);
            else send(frame_q[i], int'($urandom_range(maxgap, 0)));
        end
        go_idle();
    endtask

    task automatic check_frame(input string tag, input int extra_bytes);
        int guard = 0;
        int nobs;
        while ((done_cnt + err_cnt) == (b_done + b_err) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_end_wait"}, 32'(guard < 100), 32'd1);
        repeat (2) @(negedge clk);
        nobs = obs_addr_q.size() - b_obs;
        chk({tag, "_wr_count"}, 32'(nobs), 32'(exp_addr_q.size()));
        for (int i = 0; i < exp_addr_q.size() && i < nobs; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), obs_addr_q[b_obs + i], exp_addr_q[i]);
            chk($sformatf("%s_data%0d", tag, i), obs_data_q[b_obs + i], exp_data_q[i]);
        end
        chk({tag, "_done"}, 32'(done_cnt - b_done), 32'(exp_ok ? 1 : 0));
        chk({tag, "_error"}, 32'(err_cnt - b_err), 32'(exp_ok ? 0 : 1));
        chk({tag, "_hold_after"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_hold_at_pulse"}, 32'(hold_viol - b_hold), 32'd0);
        chk({tag, "_ready_vs_we"}, 32'(ready_viol - b_ready), 32'd0);
        chk({tag, "_bytes_taken"}, 32'(acc_cnt - b_acc), 32'(frame_q.size() + extra_bytes));
        if (exp_addr_q.size() > 0) begin
            chk({tag, "_addr_hold"}, 32'(mem_addr), exp_addr_q[exp_addr_q.size() - 1]);
            chk({tag, "_din_hold"}, 32'(mem_din), exp_data_q[exp_data_q.size() - 1]);
        end
    endtask

    initial begin
        int k;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(rx_ready), 32'd1);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_din", 32'(mem_din), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Reference frame A5,02,01,F9,00,90,8A
        hi_a[0] = 8'h01; lo_a[0] = 8'hF9; hi_a[1] = 8'h00; lo_a[1] = 8'h90;
        build_frame(2, -1, 1'b0);
        chk("t035_ck_byte", 32'(frame_q[6]), 32'h8A);
        mark();
        send_frame(2, -1);
        check_frame("t035", 0);
        if (obs_addr_q.size() >= b_obs + 2) begin
            chk("t035_lit_d0", obs_data_q[b_obs], 32'h1F9);
            chk("t035_lit_d1", obs_data_q[b_obs + 1], 32'h090);
        end

        // Same frame, checksum byte 0x00
        build_frame(2, 0, 1'b0);
        mark();
        send_frame(1, -1);
        check_frame("t036", 0);

        // Leading junk bytes then a valid frame
        fill_random(3);
        build_frame(3, -1, 1'b0);
        mark();
        send(8'h33, 0);
        send(8'h7E, 1);
        send_frame(2, -1);
        check_frame("t037", 2);

        // Stall mid-frame until timeout
        mark();
        send(8'hA5, 0);
        send(8'h01, 0);
        send(8'h0F, 0);
        @(negedge clk);
        rx_valid = 1'b0;
        k = 1;
        while (!error && k < TMO + 20) begin
            @(negedge clk);
            k++;
        end
        chk("t038_err_seen", 32'(error), 32'd1);
        chk("t038_err_lo", 32'(k >= TMO), 32'd1);
        chk("t038_err_hi", 32'(k <= TMO + 2), 32'd1);
        @(negedge clk);
        chk("t038_no_we", 32'(obs_addr_q.size() - b_obs), 32'd0);
        chk("t038_no_done", 32'(done_cnt - b_done), 32'd0);
        chk("t038_hold", 32'(cpu_hold), 32'd0);
        chk("t038_ready", 32'(rx_ready), 32'd1);

        // rx_valid held continuously
        fill_random(5);
        build_frame(5, -1, 1'b0);
        mark();
        send_frame(0, -1);
        check_frame("t039", 0);

        // Reset after hi byte of word 1
        fill_random(2);
        build_frame(2, -1, 1'b0);
        mark();
        for (int i = 0; i < 5; i++) send(frame_q[i], 0);
        @(negedge clk);
        reset = 1'b1;
        rx_valid = 1'b0;
        #1;
        chk("t040_ready", 32'(rx_ready), 32'd1);
        chk("t040_hold", 32'(cpu_hold), 32'd0);
        chk("t040_we", 32'(mem_we), 32'd0);
        chk("t040_addr", 32'(mem_addr), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("t040_wr_before", 32'(obs_addr_q.size() - b_obs), 32'd1);
        if (obs_addr_q.size() > b_obs) chk("t040_d0", obs_data_q[b_obs], exp_data_q[0]);
        send(frame_q[5], 0);
        send(frame_q[6], 0);
        go_idle();
        repeat (TMO + 10) @(negedge clk);
        chk("t040_wr_after", 32'(obs_addr_q.size() - b_obs), 32'd1);
        chk("t040_no_done", 32'(done_cnt - b_done), 32'd0);
        chk("t040_no_err", 32'(err_cnt - b_err), 32'd0);
        chk("t040_idle", 32'(cpu_hold), 32'd0);

        // Long gap just under the timeout before the checksum
        fill_random(1);
        build_frame(1, -1, 1'b0);
        mark();
        send_frame(1, TMO - 2);
        check_frame("gap", 0);

        // Count byte 0: every address written once
        fill_random(NW);
        build_frame(NW, -1, 1'b0);
        mark();
        send_frame(1, -1);
        check_frame("cnt0", 0);

        // Random frames, some with 0xA5 data and bad checksums
        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(NW, 1));
            fill_random(n);
            if (r == 1) begin
                hi_a[0] = 8'hA5;
                lo_a[0] = 8'hA5;
            end
            build_frame(n, -1, (r % 3) == 2);
            mark();
            send_frame(3, -1);
            check_frame($sformatf("rnd%0d", r), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, program RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 12, program RAM word width; two bytes carry one word.
REQ-003 SHALL have parameter TIMEOUT, default 50000, idle cycles allowed between bytes while busy.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port rx_data  input  8  byte from serial receiver.
REQ-007 SHALL have port rx_valid  input  1  rx_data valid this cycle.
REQ-008 SHALL have port rx_ready  output  1  loader accepts byte this cycle.
REQ-009 SHALL have port mem_addr  output  ADDR_WIDTH  RAM address (drives RAM addr).
REQ-010 SHALL have port mem_din  output  DATA_WIDTH  RAM write data.
REQ-011 SHALL have port mem_we  output  1  RAM write enable, one-cycle pulse.
REQ-012 SHALL have port cpu_hold  output  1  holds CPU stalled while a load is in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse, load completed with good checksum.
REQ-014 SHALL have port error  output  1  one-cycle pulse, load aborted.

Function
REQ-015 Byte SHALL be accepted only on a cycle where rx_valid and rx_ready are both 1.
REQ-016 Frame SHALL be: sync 0xA5, count byte N (0 means 2^ADDR_WIDTH words), N word pairs (hi byte then lo byte), checksum byte.
REQ-017 Word SHALL be {hi[DATA_WIDTH-9:0], lo[7:0]}; unused hi bits ignored, excluded from nothing (checksum covers full bytes).
REQ-018 States SHALL be IDLE, COUNT, HI, LO, WRITE, CHECK.
REQ-019 IDLE: accepted 0xA5 -> COUNT; any other accepted byte discarded, stay IDLE, no error.
REQ-020 COUNT: accepted byte latched as word count, word index cleared to 0, checksum cleared to 0 -> HI.
REQ-021 HI: accepted byte latched, added to checksum -> LO.
REQ-022 LO: accepted byte added to checksum, word assembled -> WRITE.
REQ-023 WRITE: mem_we=1 for exactly this cycle, mem_addr=word index, mem_din=assembled word, rx_ready=0; next index+1; -> CHECK if last word written, else HI.
REQ-024 CHECK: accepted byte equal to 8-bit modular checksum -> IDLE with done pulse next cycle; unequal -> IDLE with error pulse next cycle.
REQ-025 rx_ready SHALL be 1 in IDLE, COUNT, HI, LO, CHECK and 0 in WRITE.
REQ-026 cpu_hold SHALL be 1 in every state except IDLE; deasserts in the same cycle done or error pulses.
REQ-027 Word index SHALL wrap modulo 2^ADDR_WIDTH; count 0 writes all addresses 0..2^ADDR_WIDTH-1 once.
REQ-028 Timeout counter SHALL clear on every accepted byte and in IDLE; reaching TIMEOUT in COUNT/HI/LO/CHECK -> IDLE with error pulse.
REQ-029 Already-written words SHALL NOT be rolled back on error or timeout.
REQ-030 mem_addr and mem_din SHALL hold their last values outside WRITE; mem_we=0 outside WRITE.
REQ-031 A 0xA5 byte inside a frame SHALL be treated as data, not resync.
REQ-032 Latency: mem_we asserts exactly one cycle after the lo byte handshake.

Reset
REQ-033 Reset asserted SHALL immediately force IDLE, rx_ready=1, mem_we=0, cpu_hold=0, done=0, error=0, mem_addr=0, mem_din=0, counters and checksum 0.
REQ-034 Reset mid-frame SHALL abandon the frame with no done or error pulse; next frame requires fresh 0xA5.

Verification
REQ-035 Bytes A5,02,01,F9,00,90,8A (sum 0x8A... checksum = (01+F9+00+90)&FF=0x8A) -> writes 0x1F9@0, 0x090@1, done pulse, cpu_hold low after.
REQ-036 Same frame with checksum byte 0x00 -> both writes occur, error pulse, no done.
REQ-037 Bytes 33,7E then valid frame -> leading bytes ignored, frame loads normally.
REQ-038 A5,01,0F then rx_valid low for TIMEOUT cycles -> error pulse, IDLE, no mem_we.
REQ-039 rx_valid held high continuously through frame -> rx_ready low exactly on each WRITE cycle, no byte lost or duplicated.
REQ-040 Reset asserted after hi byte of word 1 -> immediate IDLE, no further mem_we, no done/error.
